filter_receiver: RTL and testbench

- Allocator-side endpoint of the filter broadcast stream.
- Captures each broadcast (counter, weight) pair while en is high and buffers it in a small FIFO.
- Drives the per-allocator block signal back to the broadcaster so the stream stalls before the FIFO overflows.
- Presents buffered entries to the allocator datapath over a valid/ready port, checks counter sequence, and flags completion once the whole filter is received and drained.

---
 rtl/filter_receiver_if.sv | 25 ++
 rtl/filter_receiver.sv | 124 ++++++++++++
 tb/tb_filter_receiver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/filter_receiver_if.sv
// Broadcast-in / allocator-out handshake bundle for the filter receiver.
// The slave side is the receiver; the master side is its environment.
interface filter_receiver_if #(
  parameter int CNT_W  = 13,
  parameter int DATA_W = 18
);
  logic              bc_en;
  logic [CNT_W-1:0]  bc_counter;
  logic [DATA_W-1:0] bc_data;
  logic              block;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_counter;
  logic [DATA_W-1:0] out_data;

  modport master (
    output bc_en, bc_counter, bc_data, out_ready,
    input  block, out_valid, out_counter, out_data
  );

  modport slave (
    input  bc_en, bc_counter, bc_data, out_ready,
    output block, out_valid, out_counter, out_data
  );
endinterface

// File: rtl/filter_receiver.sv
// Allocator-side endpoint of the filter broadcast: buffers (counter, weight)
// pairs in a FIFO, back-pressures the broadcaster, checks sequence, flags done.
module filter_receiver #(
  parameter int DEPTH = 8,
  parameter int SKID  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  filter_receiver_if.slave       bus,
  input  logic [12:0]            filter_length,
  output logic                   done,
  output logic                   seq_err,
  output logic                   overflow
);

  localparam int CNT_W  = 13;
  localparam int DATA_W = 18;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);

  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_THRESH = OCC_W'(DEPTH - SKID);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  mem_counter [DEPTH];
  logic [DATA_W-1:0] mem_data    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] accepted;

  logic             head_vld;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [OCC_W-1:0] occ_nxt;
  logic [CNT_W-1:0] acc_nxt;
  logic             done_set;

  assign head_vld = (occ != '0);
  assign full     = (occ == OCC_FULL);
  assign pop      = head_vld & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = bus.bc_en & (~full | pop);
  assign drop     = bus.bc_en & full & ~pop;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop) begin
      occ_nxt = occ + OCC_W'(1);
    end else if (!push && pop) begin
      occ_nxt = occ - OCC_W'(1);
    end
  end

  assign acc_nxt  = push ? sat_inc(accepted) : accepted;
  assign done_set = (acc_nxt >= filter_length) && (occ_nxt == '0);

  assign bus.out_valid   = head_vld;
  assign bus.out_counter = head_vld ? mem_counter[rd_ptr] : '0;
  assign bus.out_data    = head_vld ? mem_data[rd_ptr]    : '0;

  // Storage: data only, no reset; pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_counter[wr_ptr] <= bus.bc_counter;
      mem_data[wr_ptr]    <= bus.bc_data;
    end
  end

  // Control: pointers, occupancy, sequence tracking and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      expected  <= '0;
      accepted  <= '0;
      bus.block <= 1'b0;
      done      <= 1'b0;
      seq_err   <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      expected  <= '0;
      accepted  <= '0;
      bus.block <= 1'b0;
      done      <= 1'b0;
      seq_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        // Resync on the received value so one gap raises only one error.
        expected <= bus.bc_counter + CNT_W'(1);
        if (bus.bc_counter != expected) begin
          seq_err <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (done_set) begin
        done <= 1'b1;
      end
      occ       <= occ_nxt;
      accepted  <= acc_nxt;
      bus.block <= (occ_nxt >= OCC_THRESH);
    end
  end

endmodule

// File: tb/tb_filter_receiver.sv
// Directed bench for filter_receiver: per-cycle vector table plus hand-written
// sequences for back-pressure, overflow, clear and asynchronous reset.
module tb_filter_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [12:0] filter_length;
  logic        done;
  logic        seq_err;
  logic        overflow;

  filter_receiver_if bus ();

  filter_receiver #(.DEPTH(8), .SKID(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .bus           (bus),
    .filter_length (filter_length),
    .done          (done),
    .seq_err       (seq_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        clr;
    logic        en;
    logic [12:0] cnt;
    logic [17:0] dat;
    logic        rdy;
    logic [12:0] fl;
    logic        ov;
    logic [12:0] oc;
    logic [17:0] od;
    logic        blk;
    logic        dn;
    logic        se;
    logic        of;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic clr, input logic en, input int cnt, input int dat,
                              input logic rdy, input int fl, input logic ov, input int oc,
                              input int od, input logic blk, input logic dn, input logic se,
                              input logic of);
    vec_t m;
    m.clr = clr; m.en = en; m.cnt = 13'(cnt); m.dat = 18'(dat); m.rdy = rdy; m.fl = 13'(fl);
    m.ov = ov; m.oc = 13'(oc); m.od = 18'(od); m.blk = blk; m.dn = dn; m.se = se; m.of = of;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int n, input int base);
    bus.bc_en      = 1'b1;
    bus.bc_counter = 13'(n);
    bus.bc_data    = 18'(base + n);
    step();
  endtask

  task automatic fill8(input int fl);
    clear = 1'b1; bus.bc_en = 1'b0; bus.out_ready = 1'b0; filter_length = 13'(fl);
    step();
    clear = 1'b0;
    for (int n = 0; n < 8; n++) push_one(n, 'h500);
    bus.bc_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [35:0] act;
    logic [35:0] exp;
    int          nxt;
    int          exp_head;

    rst = 1'b0; clear = 1'b0; filter_length = 13'd5;
    bus.bc_en = 1'b0; bus.bc_counter = '0; bus.bc_data = '0; bus.out_ready = 1'b0;

    //           clr en cnt dat    rdy fl  ov oc dat    blk dn se of
    tv.push_back(mk(0, 1, 0, 'h100, 1, 5,  1, 0, 'h100, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 'h101, 1, 5,  1, 1, 'h101, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 2, 'h102, 1, 5,  1, 2, 'h102, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 3, 'h103, 1, 5,  1, 3, 'h103, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 4, 'h104, 1, 5,  1, 4, 'h104, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 5,  0, 0, 0,     0, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 5,  0, 0, 0,     0, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,     1, 4,  0, 0, 0,     0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 'h200, 1, 4,  1, 0, 'h200, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 'h201, 1, 4,  1, 1, 'h201, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 3, 'h203, 1, 4,  1, 3, 'h203, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 4, 'h204, 1, 4,  1, 4, 'h204, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 4,  0, 0, 0,     0, 1, 1, 0));
    tv.push_back(mk(1, 0, 0, 0,     0, 5,  0, 0, 0,     0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 'h300, 0, 5,  1, 0, 'h300, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 'h301, 0, 5,  1, 0, 'h300, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 2, 'h302, 0, 5,  1, 0, 'h300, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 3, 'h303, 0, 5,  0, 0, 0,     0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 'h310, 1, 5,  1, 0, 'h310, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 5,  0, 0, 0,     0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0,     0, 0,  0, 0, 0,     0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0,  0, 0, 0,     0, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 'h320, 0, 0,  1, 0, 'h320, 0, 1, 0, 0));
    tv.push_back(mk(0, 1, 5, 'h325, 1, 0,  1, 5, 'h325, 0, 1, 1, 0));

    // Reset state, including the head fields.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.out_valid, bus.out_counter, bus.out_data, bus.block,
                        done, seq_err, overflow}, 64'd0);
    rst = 1'b1;

    foreach (tv[i]) begin
      clear = tv[i].clr; bus.bc_en = tv[i].en; bus.bc_counter = tv[i].cnt;
      bus.bc_data = tv[i].dat; bus.out_ready = tv[i].rdy; filter_length = tv[i].fl;
      step();
      act = {bus.out_valid, tv[i].ov ? bus.out_counter : 13'd0, tv[i].ov ? bus.out_data : 18'd0,
             bus.block, done, seq_err, overflow};
      exp = {tv[i].ov, tv[i].oc, tv[i].od, tv[i].blk, tv[i].dn, tv[i].se, tv[i].of};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end
    clear = 1'b0;

    // Back-pressure: broadcaster drops en as soon as it sees block.
    clear = 1'b1; bus.bc_en = 1'b0; bus.out_ready = 1'b0; filter_length = 13'd10;
    step();
    clear = 1'b0;
    for (int n = 0; n < 6; n++) begin
      push_one(n, 'h400);
      chk($sformatf("bp_block%0d", n), 64'(bus.block), 64'(n == 5));
    end
    bus.bc_en = ~bus.block;
    step();
    chk("bp_hold", {60'd0, bus.out_valid, bus.block, overflow, bus.bc_en}, 64'b1100);
    chk("bp_head0", 64'(bus.out_counter), 64'd0);
    bus.out_ready = 1'b1;
    nxt = 6; exp_head = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("bp_head%0d", exp_head), {bus.out_counter, bus.out_data},
            {13'(exp_head), 18'('h400 + exp_head)});
        exp_head++;
      end
      bus.bc_en = (nxt < 10) && !bus.block;
      bus.bc_counter = 13'(nxt);
      bus.bc_data = 18'('h400 + nxt);
      if (bus.bc_en) nxt++;
      step();
      if (c == 0) chk("bp_unblock", 64'(bus.block), 64'd0);
    end
    bus.bc_en = 1'b0;
    chk("bp_count", 64'(exp_head), 64'd10);
    chk("bp_flags", {59'd0, done, seq_err, overflow, bus.block, bus.out_valid}, 64'b10000);

    // Full FIFO with no pop: the extra entry is dropped.
    fill8(20);
    push_one(8, 'h500);
    bus.bc_en = 1'b0;
    chk("of_drop", {bus.out_counter, overflow, bus.out_valid, bus.block}, {13'd0, 3'b111});

    // Full FIFO with a concurrent pop: both happen, no overflow.
    fill8(20);
    chk("of_full", {overflow, bus.block, bus.out_valid}, 3'b011);
    bus.out_ready = 1'b1;
    push_one(8, 'h500);
    bus.bc_en = 1'b0;
    chk("of_pushpop", {bus.out_counter, overflow, bus.out_valid, bus.block}, {13'd1, 3'b011});
    exp_head = 1;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("of_head%0d", exp_head), {bus.out_counter, bus.out_data},
            {13'(exp_head), 18'('h500 + exp_head)});
        exp_head++;
      end
      step();
    end
    chk("of_drained", 64'(exp_head), 64'd9);
    chk("of_flags", {61'd0, overflow, seq_err, bus.out_valid}, 64'd0);

    // Asynchronous reset mid-stream with block and done both high.
    clear = 1'b1; bus.out_ready = 1'b0; filter_length = 13'd0;
    step();
    clear = 1'b0;
    step();
    for (int n = 0; n < 6; n++) push_one(n, 'h600);
    bus.bc_en = 1'b0;
    chk("ar_pre", {bus.block, bus.out_valid, done}, 3'b111);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_async", {bus.block, bus.out_valid, done}, 3'b000);
    step();
    rst = 1'b1; filter_length = 13'd5;
    push_one(0, 'h700);
    bus.bc_en = 1'b0;
    chk("ar_restart", {bus.out_valid, bus.out_counter, bus.out_data, seq_err},
        {1'b1, 13'd0, 18'h700, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
